// File: rtl/f_u_rca_chunk_seq.sv
// f_u_rca_chunk_seq: wide unsigned adder reusing one WIDTH-bit ripple-carry slice, one chunk per cycle.
// Define RCA_SEQ_SUB_EN to add the sub port (a-b via inverted b and carry-in of 1).
module f_u_rca_chunk_seq #(
    parameter int WIDTH  = 12,
    parameter int CHUNKS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH*CHUNKS-1:0]   a,
    input  logic [WIDTH*CHUNKS-1:0]   b,
`ifdef RCA_SEQ_SUB_EN
    input  logic                      sub,
`endif
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH*CHUNKS:0]     out_sum,
    output logic                      busy
);
    localparam int N  = WIDTH * CHUNKS;
    localparam int CW = CHUNKS > 1 ? $clog2(CHUNKS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             r_state, w_next;
    logic [N-1:0]       r_a, r_b, r_sum;
    logic               r_carry, r_cout;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   w_bs, w_s;
    logic [WIDTH:0]     w_c;
    logic [N+WIDTH-1:0] w_cat;
    logic               w_acc, w_last, w_cin0;

`ifdef RCA_SEQ_SUB_EN
    logic r_sub;
    assign w_bs   = r_b[WIDTH-1:0] ^ {WIDTH{r_sub}};
    assign w_cin0 = sub;
`else
    assign w_bs   = r_b[WIDTH-1:0];
    assign w_cin0 = 1'b0;
`endif

    assign w_c[0] = r_carry;
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign w_s[i]   = r_a[i] ^ w_bs[i] ^ w_c[i];
        assign w_c[i+1] = (r_a[i] & w_bs[i]) | (w_c[i] & (r_a[i] ^ w_bs[i]));
    end

    // New slice sum enters at the top; after CHUNKS steps chunk 0 sits at the bottom.
    assign w_cat   = {w_s, r_sum};
    assign w_acc   = in_valid && r_state == IDLE;
    assign w_last  = r_cnt == CW'(CHUNKS - 1);
    assign out_sum = {r_cout, r_sum};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = (r_state == IDLE && in_valid)  ? RUN  :
                    (r_state == RUN  && w_last)    ? DONE :
                    (r_state == DONE && out_ready) ? IDLE : r_state;
        in_ready  = r_state == IDLE;
        out_valid = r_state == DONE;
        busy      = r_state != IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
`ifdef RCA_SEQ_SUB_EN
            r_sub   <= 1'b0;
`endif
        end else if (w_acc) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= w_cin0;
            r_cnt   <= '0;
`ifdef RCA_SEQ_SUB_EN
            r_sub   <= sub;
`endif
        end else if (r_state == RUN) begin
            r_a     <= r_a >> WIDTH;
            r_b     <= r_b >> WIDTH;
            r_sum   <= w_cat[N+WIDTH-1:WIDTH];
            r_carry <= w_c[WIDTH];
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) r_cout <= w_c[WIDTH];
        end
    end
endmodule

// File: tb/tb_f_u_rca_chunk_seq.sv
// tb_f_u_rca_chunk_seq: randomized bench with a queue-based arithmetic model of f_u_rca_chunk_seq.
// Subtraction cases run only when RCA_SEQ_SUB_EN is defined.
module tb_f_u_rca_chunk_seq;
    localparam int W = 12;
    localparam int C = 4;
    localparam int N = W * C;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         sub = 1'b0;
    logic         in_ready, out_valid, busy;
    logic [N:0]   out_sum;

    always #5 clk = ~clk;

    f_u_rca_chunk_seq #(.WIDTH(W), .CHUNKS(C)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b),
`ifdef RCA_SEQ_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .busy(busy)
    );

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int acc_cyc = -1;
    logic prev_v = 1'b0;
    logic [N:0] q[$];
    int rise_cyc[$];

    task automatic chk(string nm, logic [N:0] act, logic [N:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [N:0] model(logic [N-1:0] x, logic [N-1:0] y, logic s);
`ifdef RCA_SEQ_SUB_EN
        if (s) return {(x >= y), N'(x - y)};
`endif
        return {1'b0, x} + {1'b0, y} + (N+1)'(s & 1'b0);
    endfunction

    // Everything is judged at the falling edge, before the next rising edge acts on it.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            q.delete();
            prev_v = 1'b0;
            acc_cyc = -1;
        end else begin
            chk("busy", (N+1)'(busy), (N+1)'(q.size() > 0));
            chk("in_ready", (N+1)'(in_ready), (N+1)'(q.size() == 0));
            if (out_valid) begin
                if (q.size() == 0) chk("unexpected_valid", (N+1)'(1), (N+1)'(0));
                else chk("out_sum", out_sum, q[0]);
                if (!prev_v) begin
                    chk("latency", (N+1)'(cyc - acc_cyc), (N+1)'(C + 1));
                    rise_cyc.push_back(cyc);
                end
                if (out_ready && q.size() > 0) void'(q.pop_front());
            end
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, sub));
                acc_cyc = cyc;
            end
            prev_v = out_valid;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(logic [N-1:0] x, logic [N-1:0] y, logic s);
        int k = 0;
        a = x; b = y; sub = s; in_valid = 1'b1;
        while (!in_ready && k < 100) begin step(); k++; end
        if (k == 100) chk("send_timeout", (N+1)'(0), (N+1)'(1));
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!out_valid && k < 100) begin step(); k++; end
        if (k == 100) chk("valid_timeout", (N+1)'(0), (N+1)'(1));
    endtask

    task automatic drain();
        int k = 0;
        while (q.size() > 0 && k < 300) begin
            out_ready = 1'($urandom_range(0, 1));
            step();
            k++;
        end
        if (k == 300) chk("drain_timeout", (N+1)'(0), (N+1)'(1));
        out_ready = 1'b0;
    endtask

    task automatic literal(logic [N-1:0] x, logic [N-1:0] y, logic s, logic [N:0] exp, string nm);
        send(x, y, s);
        wait_valid();
        chk(nm, out_sum, exp);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #1 rst_n = 1'b0;
        step(); step();
        chk("rst_out_valid", (N+1)'(out_valid), (N+1)'(0));
        chk("rst_busy", (N+1)'(busy), (N+1)'(0));
        chk("rst_in_ready", (N+1)'(in_ready), (N+1)'(1));
        chk("rst_out_sum", out_sum, '0);
        rst_n = 1'b1;
        step();

        literal(48'hFFFF_FFFF_FFFF, 48'h1, 1'b0, 49'h1_0000_0000_0000, "t1_carry_out");
        literal(48'h123_456_789_ABC, 48'h111_111_111_111, 1'b0, 49'h0_2345_6789_ABCD, "t2_sum");

        // Stall in DONE while offering fresh operands.
        send(48'h123_456_789_ABC, 48'h111_111_111_111, 1'b0);
        wait_valid();
        a = 48'hAAAA_AAAA_AAAA; b = 48'h5555_5555_5555; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t3_hold_valid", (N+1)'(out_valid), (N+1)'(1));
            chk("t3_hold_sum", out_sum, 49'h0_2345_6789_ABCD);
        end
        chk("t3_no_accept", (N+1)'(in_ready), (N+1)'(0));
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset two slices into RUN.
        send(48'h123_456_789_ABC, 48'h111_111_111_111, 1'b0);
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        chk("t4_rst_valid", (N+1)'(out_valid), (N+1)'(0));
        chk("t4_rst_busy", (N+1)'(busy), (N+1)'(0));
        chk("t4_rst_sum", out_sum, '0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        step();
        literal(48'h123_456_789_ABC, 48'h111_111_111_111, 1'b0, 49'h0_2345_6789_ABCD, "t4_after_rst");

        // Streaming at full rate.
        step();
        rise_cyc.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(N'({$urandom, $urandom}), N'({$urandom, $urandom}), 1'b0);
        begin
            int k = 0;
            while ((rise_cyc.size() < 3 || q.size() > 0) && k < 100) begin step(); k++; end
        end
        out_ready = 1'b0;
        chk("t5_pulses", (N+1)'(rise_cyc.size()), (N+1)'(3));
        if (rise_cyc.size() >= 3) begin
            chk("t5_gap1", (N+1)'(rise_cyc[1] - rise_cyc[0]), (N+1)'(C + 2));
            chk("t5_gap2", (N+1)'(rise_cyc[2] - rise_cyc[1]), (N+1)'(C + 2));
        end

`ifdef RCA_SEQ_SUB_EN
        literal(48'd7, 48'd5, 1'b1, 49'h1_0000_0000_0002, "t6_sub_pos");
        literal(48'd5, 48'd7, 1'b1, 49'h0_FFFF_FFFF_FFFE, "t6_sub_neg");
`endif

        for (int i = 0; i < 40; i++) begin
            logic [N-1:0] x, y;
            x = (i == 0) ? '1 : (i == 1) ? '0 : N'({$urandom, $urandom});
            y = (i == 0) ? '1 : (i == 1) ? '0 : N'({$urandom, $urandom});
`ifdef RCA_SEQ_SUB_EN
            send(x, y, 1'($urandom_range(0, 1)));
`else
            send(x, y, 1'b0);
`endif
            drain();
            repeat ($urandom_range(0, 2)) step();
        end

        chk("queue_empty", (N+1)'(q.size()), (N+1)'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
